// File: rtl/usbfs_dev_txn_ctrl_if.sv
// Receiver/transmitter bundle between the USB FS packet PHY layer
// and the device transaction sequencer.
interface usbfs_dev_txn_ctrl_if;
   logic       i_rxEop;
   logic [3:0] i_rxPid;
   logic [6:0] i_rxAddr;
   logic [3:0] i_rxEndp;
   logic       i_rxPidOkay;
   logic       i_rxTokenOkay;
   logic       i_rxDataOkay;
   logic       o_txValid;
   logic       i_txReady;
   logic [3:0] o_txPid;
   logic       i_txEopDone;

   modport master (
      input  i_rxEop, i_rxPid, i_rxAddr, i_rxEndp,
      input  i_rxPidOkay, i_rxTokenOkay, i_rxDataOkay,
      input  i_txReady, i_txEopDone,
      output o_txValid, o_txPid
   );

   modport slave (
      output i_rxEop, i_rxPid, i_rxAddr, i_rxEndp,
      output i_rxPidOkay, i_rxTokenOkay, i_rxDataOkay,
      output i_txReady, i_txEopDone,
      input  o_txValid, o_txPid
   );
endinterface

// File: rtl/usbfs_dev_txn_ctrl.sv
// Device-side USB FS transaction sequencer: picks handshake/data PID,
// tracks DATA0/DATA1 toggles and pulses buffer commits.
module usbfs_dev_txn_ctrl #(
   parameter int N_ENDP  = 2,
   parameter int TIMEOUT = 18
) (
   input  logic              i_clk_48MHz,
   input  logic              i_rstn,
   input  logic              i_strobe_12MHz,
   input  logic [6:0]        i_devAddr,
   usbfs_dev_txn_ctrl_if.master bus,
   input  logic [N_ENDP-1:0] i_inReady,
   input  logic [N_ENDP-1:0] i_outSpace,
   input  logic [N_ENDP-1:0] i_stall,
   output logic [3:0]        o_endp,
   output logic              o_setup,
   output logic              o_outCommit,
   output logic              o_inCommit,
   output logic              o_busy
);

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   localparam int EW = (N_ENDP > 1) ? $clog2(N_ENDP) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [4:0] NE = 5'(N_ENDP);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      TX_REQ,
      TX_BUSY,
      WAIT_HSK
   } state_t;

   state_t            state;
   logic              after_tx;
   logic              is_setup;
   logic [CW-1:0]     cnt;
   logic [N_ENDP-1:0] out_tog;
   logic [N_ENDP-1:0] in_tog;

   logic          tok_ok;
   logic          data_ok;
   logic          tmo;
   logic          tog_match;
   logic [EW-1:0] ti;
   logic [EW-1:0] cur;

   assign ti  = bus.i_rxEndp[EW-1:0];
   assign cur = o_endp[EW-1:0];

   assign tok_ok = bus.i_rxEop && bus.i_rxPidOkay &&
                   bus.i_rxTokenOkay &&
                   (bus.i_rxAddr == i_devAddr) &&
                   ({1'b0, bus.i_rxEndp} < NE);

   assign data_ok = bus.i_rxEop && bus.i_rxPidOkay &&
                    bus.i_rxDataOkay &&
                    ((bus.i_rxPid == PID_DATA0) ||
                     (bus.i_rxPid == PID_DATA1));

   assign tmo = i_strobe_12MHz && (cnt == CNT_LAST);

   assign tog_match = ((bus.i_rxPid == PID_DATA1) == out_tog[cur]);

   // Transaction FSM with registered tx request, pulses and toggles.
   always_ff @(posedge i_clk_48MHz) begin
      if (!i_rstn) begin
         state         <= IDLE;
         after_tx      <= 1'b0;
         is_setup      <= 1'b0;
         cnt           <= '0;
         out_tog       <= '0;
         in_tog        <= '0;
         bus.o_txValid <= 1'b0;
         bus.o_txPid   <= 4'b0000;
         o_endp        <= 4'd0;
         o_setup       <= 1'b0;
         o_outCommit   <= 1'b0;
         o_inCommit    <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         o_setup     <= 1'b0;
         o_outCommit <= 1'b0;
         o_inCommit  <= 1'b0;
         case (state)
            IDLE: begin
               if (tok_ok) begin
                  case (bus.i_rxPid)
                     PID_OUT, PID_SETUP: begin
                        o_endp   <= bus.i_rxEndp;
                        o_busy   <= 1'b1;
                        is_setup <= (bus.i_rxPid == PID_SETUP);
                        cnt      <= '0;
                        state    <= WAIT_DATA;
                     end
                     PID_IN: begin
                        o_endp        <= bus.i_rxEndp;
                        o_busy        <= 1'b1;
                        bus.o_txValid <= 1'b1;
                        state         <= TX_REQ;
                        if (i_stall[ti]) begin
                           bus.o_txPid <= PID_STALL;
                           after_tx    <= 1'b0;
                        end else if (i_inReady[ti]) begin
                           bus.o_txPid <= in_tog[ti] ? PID_DATA1
                                                     : PID_DATA0;
                           after_tx    <= 1'b1;
                        end else begin
                           bus.o_txPid <= PID_NAK;
                           after_tx    <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            WAIT_DATA: begin
               if (bus.i_rxEop) begin
                  if (data_ok) begin
                     bus.o_txValid <= 1'b1;
                     after_tx      <= 1'b0;
                     state         <= TX_REQ;
                     if (is_setup) begin
                        bus.o_txPid  <= PID_ACK;
                        o_setup      <= 1'b1;
                        out_tog[cur] <= 1'b1;
                        in_tog[cur]  <= 1'b1;
                     end else if (i_stall[cur]) begin
                        bus.o_txPid <= PID_STALL;
                     end else if (!i_outSpace[cur]) begin
                        bus.o_txPid <= PID_NAK;
                     end else begin
                        bus.o_txPid <= PID_ACK;
                        if (tog_match) begin
                           o_outCommit  <= 1'b1;
                           out_tog[cur] <= ~out_tog[cur];
                        end
                     end
                  end else begin
                     o_busy <= 1'b0;
                     state  <= IDLE;
                  end
               end else if (tmo) begin
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end else if (i_strobe_12MHz) begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_REQ: begin
               if (bus.i_txReady) begin
                  bus.o_txValid <= 1'b0;
                  state         <= TX_BUSY;
               end
            end
            TX_BUSY: begin
               if (bus.i_txEopDone) begin
                  if (after_tx) begin
                     cnt   <= '0;
                     state <= WAIT_HSK;
                  end else begin
                     o_busy <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end
            WAIT_HSK: begin
               if (bus.i_rxEop) begin
                  if (bus.i_rxPidOkay && bus.i_rxPid == PID_ACK) begin
                     o_inCommit  <= 1'b1;
                     in_tog[cur] <= ~in_tog[cur];
                  end
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end else if (tmo) begin
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end else if (i_strobe_12MHz) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usbfs_dev_txn_ctrl.sv
// Directed bench for usbfs_dev_txn_ctrl: transaction table plus
// hand sequences for timeout, back-pressure and reset corners.
module tb_usbfs_dev_txn_ctrl;

   localparam logic [3:0] P_OUT   = 4'b0001;
   localparam logic [3:0] P_IN    = 4'b1001;
   localparam logic [3:0] P_SETUP = 4'b1101;
   localparam logic [3:0] P_D0    = 4'b0011;
   localparam logic [3:0] P_D1    = 4'b1011;
   localparam logic [3:0] P_ACK   = 4'b0010;
   localparam logic [3:0] P_NAK   = 4'b1010;
   localparam logic [3:0] P_STALL = 4'b1110;
   localparam logic [6:0] DEV     = 7'h2A;

   logic       clk = 1'b0;
   logic       rstn;
   logic       strobe;
   logic [1:0] in_rdy;
   logic [1:0] out_sp;
   logic [1:0] stall;
   logic [3:0] endp;
   logic       setup_p;
   logic       out_c;
   logic       in_c;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   usbfs_dev_txn_ctrl_if bus ();

   usbfs_dev_txn_ctrl #(.N_ENDP(2), .TIMEOUT(18)) dut (
      .i_clk_48MHz    (clk),
      .i_rstn         (rstn),
      .i_strobe_12MHz (strobe),
      .i_devAddr      (DEV),
      .bus            (bus.master),
      .i_inReady      (in_rdy),
      .i_outSpace     (out_sp),
      .i_stall        (stall),
      .o_endp         (endp),
      .o_setup        (setup_p),
      .o_outCommit    (out_c),
      .o_inCommit     (in_c),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] tpid;
      logic [6:0] addr;
      logic [3:0] ep;
      logic       tok_ok;
      logic [3:0] dpid;
      logic       data_ok;
      logic [1:0] in_rdy;
      logic [1:0] out_sp;
      logic [1:0] stall;
      logic       resp;
      logic [3:0] exp_pid;
      logic       exp_setup;
      logic       exp_out;
      logic       exp_in;
   } vec_t;

   vec_t vt[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic pkt(input logic [3:0] pid, input logic [6:0] a,
                      input logic [3:0] e, input logic pok,
                      input logic tok, input logic dok);
      bus.i_rxPid       = pid;
      bus.i_rxAddr      = a;
      bus.i_rxEndp      = e;
      bus.i_rxPidOkay   = pok;
      bus.i_rxTokenOkay = tok;
      bus.i_rxDataOkay  = dok;
      bus.i_rxEop       = 1'b1;
      tick();
      bus.i_rxEop       = 1'b0;
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) begin
         strobe = 1'b1;
         tick();
         strobe = 1'b0;
         tick();
      end
   endtask

   task automatic do_tx(input string nm, input logic [3:0] pid);
      chk({nm, "_valid"}, 32'(bus.o_txValid), 32'd1);
      chk({nm, "_pid"}, 32'(bus.o_txPid), 32'(pid));
      bus.i_txReady = 1'b1;
      tick();
      bus.i_txReady = 1'b0;
      chk({nm, "_drop"}, 32'(bus.o_txValid), 32'd0);
      chk({nm, "_pulse1"}, {29'd0, setup_p, out_c, in_c}, 32'd0);
      tick();
      bus.i_txEopDone = 1'b1;
      tick();
      bus.i_txEopDone = 1'b0;
   endtask

   task automatic in_ack(input string nm, input logic exp);
      chk({nm, "_hskwait"}, 32'(busy), 32'd1);
      pkt(P_ACK, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      chk({nm, "_incommit"}, 32'(in_c), 32'(exp));
      chk({nm, "_idle"}, 32'(busy), 32'd0);
      tick();
      chk({nm, "_inpulse"}, 32'(in_c), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      logic valid;
      valid  = v.tok_ok && v.addr == DEV && v.ep < 4'd2;
      in_rdy = v.in_rdy;
      out_sp = v.out_sp;
      stall  = v.stall;
      pkt(v.tpid, v.addr, v.ep, 1'b1, v.tok_ok, 1'b0);
      if (!valid) begin
         chk({v.name, "_busy"}, 32'(busy), 32'd0);
         tick();
         chk({v.name, "_notx"}, 32'(bus.o_txValid), 32'd0);
         chk({v.name, "_busy2"}, 32'(busy), 32'd0);
         return;
      end
      chk({v.name, "_busy"}, 32'(busy), 32'd1);
      chk({v.name, "_endp"}, 32'(endp), 32'(v.ep));
      if (v.tpid == P_IN) begin
         do_tx(v.name, v.exp_pid);
         if (v.exp_pid == P_D0 || v.exp_pid == P_D1)
            in_ack(v.name, v.exp_in);
         else
            chk({v.name, "_done"}, 32'(busy), 32'd0);
      end else begin
         tick();
         pkt(v.dpid, 7'd0, 4'd0, 1'b1, 1'b0, v.data_ok);
         chk({v.name, "_setup"}, 32'(setup_p), 32'(v.exp_setup));
         chk({v.name, "_outc"}, 32'(out_c), 32'(v.exp_out));
         if (!v.resp) begin
            chk({v.name, "_notx"}, 32'(bus.o_txValid), 32'd0);
            chk({v.name, "_drop"}, 32'(busy), 32'd0);
            return;
         end
         do_tx(v.name, v.exp_pid);
         chk({v.name, "_done"}, 32'(busy), 32'd0);
      end
      tick();
   endtask

   initial begin
      vt[0]  = '{"out1_d0",    P_OUT,   DEV,   4'd1, 1, P_D0, 1,
                 2'b00, 2'b11, 2'b00, 1, P_ACK,   0, 1, 0};
      vt[1]  = '{"out1_rep",   P_OUT,   DEV,   4'd1, 1, P_D0, 1,
                 2'b00, 2'b11, 2'b00, 1, P_ACK,   0, 0, 0};
      vt[2]  = '{"out1_d1",    P_OUT,   DEV,   4'd1, 1, P_D1, 1,
                 2'b00, 2'b11, 2'b00, 1, P_ACK,   0, 1, 0};
      vt[3]  = '{"in0_d0",     P_IN,    DEV,   4'd0, 1, P_D0, 1,
                 2'b01, 2'b00, 2'b00, 1, P_D0,    0, 0, 1};
      vt[4]  = '{"setup0",     P_SETUP, DEV,   4'd0, 1, P_D0, 1,
                 2'b00, 2'b00, 2'b01, 1, P_ACK,   1, 0, 0};
      vt[5]  = '{"out0_stall", P_OUT,   DEV,   4'd0, 1, P_D1, 1,
                 2'b00, 2'b11, 2'b01, 1, P_STALL, 0, 0, 0};
      vt[6]  = '{"bad_addr",   P_OUT,   7'h2B, 4'd0, 1, P_D0, 1,
                 2'b00, 2'b11, 2'b00, 0, P_ACK,   0, 0, 0};
      vt[7]  = '{"bad_endp",   P_OUT,   DEV,   4'd2, 1, P_D0, 1,
                 2'b00, 2'b11, 2'b00, 0, P_ACK,   0, 0, 0};
      vt[8]  = '{"bad_crc5",   P_OUT,   DEV,   4'd1, 0, P_D0, 1,
                 2'b00, 2'b11, 2'b00, 0, P_ACK,   0, 0, 0};
      vt[9]  = '{"out1_nak",   P_OUT,   DEV,   4'd1, 1, P_D1, 1,
                 2'b00, 2'b00, 2'b00, 1, P_NAK,   0, 0, 0};
      vt[10] = '{"in1_nak",    P_IN,    DEV,   4'd1, 1, P_D0, 1,
                 2'b00, 2'b00, 2'b00, 1, P_NAK,   0, 0, 0};
      vt[11] = '{"in1_stall",  P_IN,    DEV,   4'd1, 1, P_D0, 1,
                 2'b10, 2'b00, 2'b10, 1, P_STALL, 0, 0, 0};
      vt[12] = '{"in0_d1",     P_IN,    DEV,   4'd0, 1, P_D0, 1,
                 2'b01, 2'b00, 2'b00, 1, P_D1,    0, 0, 1};
      vt[13] = '{"out0_d1",    P_OUT,   DEV,   4'd0, 1, P_D1, 1,
                 2'b00, 2'b01, 2'b00, 1, P_ACK,   0, 1, 0};
      vt[14] = '{"out1_crc16", P_OUT,   DEV,   4'd1, 1, P_D0, 0,
                 2'b00, 2'b11, 2'b00, 0, P_ACK,   0, 0, 0};

      rstn              = 1'b0;
      strobe            = 1'b0;
      in_rdy            = '0;
      out_sp            = '0;
      stall             = '0;
      bus.i_rxEop       = 1'b0;
      bus.i_rxPid       = '0;
      bus.i_rxAddr      = '0;
      bus.i_rxEndp      = '0;
      bus.i_rxPidOkay   = 1'b0;
      bus.i_rxTokenOkay = 1'b0;
      bus.i_rxDataOkay  = 1'b0;
      bus.i_txReady     = 1'b0;
      bus.i_txEopDone   = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(bus.o_txValid), 32'd0);
      chk("rst_pid", 32'(bus.o_txPid), 32'd0);
      chk("rst_endp", 32'(endp), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pulses", {29'd0, setup_p, out_c, in_c}, 32'd0);
      rstn = 1'b1;
      tick();

      foreach (vt[i]) run_vec(vt[i]);

      // IN ep0 with silent host: abandoned after 18 strobes
      in_rdy = 2'b01;
      stall  = 2'b00;
      pkt(P_IN, DEV, 4'd0, 1'b1, 1'b1, 1'b0);
      do_tx("tmo_in", P_D0);
      strobes(17);
      chk("tmo_17", 32'(busy), 32'd1);
      strobes(1);
      chk("tmo_18", 32'(busy), 32'd0);
      chk("tmo_nocommit", 32'(in_c), 32'd0);
      pkt(P_IN, DEV, 4'd0, 1'b1, 1'b1, 1'b0);
      do_tx("tmo_retry", P_D0);
      in_ack("tmo_retry", 1'b1);

      // Transmitter back-pressure: request must hold steady
      begin
         logic stable;
         stable = 1'b1;
         out_sp = 2'b11;
         pkt(P_OUT, DEV, 4'd1, 1'b1, 1'b1, 1'b0);
         pkt(P_D0, 7'd0, 4'd0, 1'b1, 1'b0, 1'b1);
         chk("bp_commit", 32'(out_c), 32'd1);
         for (int i = 0; i < 20; i++) begin
            if (bus.o_txValid !== 1'b1 || bus.o_txPid !== P_ACK)
               stable = 1'b0;
            tick();
         end
         chk("bp_stable", 32'(stable), 32'd1);
         do_tx("bp", P_ACK);
      end

      // Reset while waiting for the host handshake
      in_rdy = 2'b01;
      pkt(P_IN, DEV, 4'd0, 1'b1, 1'b1, 1'b0);
      do_tx("rst_in", P_D1);
      chk("rst_hsk", 32'(busy), 32'd1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_valid", 32'(bus.o_txValid), 32'd0);
      tick();
      pkt(P_IN, DEV, 4'd0, 1'b1, 1'b1, 1'b0);
      do_tx("rst_intog", P_D0);
      in_ack("rst_intog", 1'b1);
      pkt(P_OUT, DEV, 4'd1, 1'b1, 1'b1, 1'b0);
      pkt(P_D0, 7'd0, 4'd0, 1'b1, 1'b0, 1'b1);
      chk("rst_outtog", 32'(out_c), 32'd1);
      do_tx("rst_out", P_ACK);

      // DATA packet on the same cycle as the 18th strobe wins
      pkt(P_OUT, DEV, 4'd1, 1'b1, 1'b1, 1'b0);
      strobes(17);
      chk("race_wait", 32'(busy), 32'd1);
      strobe = 1'b1;
      pkt(P_D1, 7'd0, 4'd0, 1'b1, 1'b0, 1'b1);
      strobe = 1'b0;
      chk("race_commit", 32'(out_c), 32'd1);
      do_tx("race", P_ACK);
      chk("race_idle", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
